// File: rtl/comet2_fetch_unit.sv
// COMET II fetch: reads 1-2 program words per instruction, valid 1 (one-word) or 2 (two-word) cycles after FETCH1.
// Holds the assembled instruction stable with re low until the decoder takes it; redirect discards any partial fetch.
module comet2_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_mclk,
  input  logic        i_rst,
  input  logic        i_run,
  output logic        o_re,
  output logic [15:0] o_raddr,
  input  logic [15:0] i_rdata,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [15:0] o_instr_word1,
  output logic [15:0] o_instr_word2,
  output logic        o_instr_len2,
  output logic [15:0] o_instr_pc,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH1,
    S_FETCH2,
    S_HOLD
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] w_pc_nxt;
  logic [15:0] r_word1;
  logic [15:0] r_word2;
  logic [15:0] r_ipc;
  logic        r_len2;
  logic        w_cap1;
  logic        w_cap2;
  logic        w_two;

  // Opcodes that carry an adr word after the opcode word.
  always_comb begin
    w_two = 1'b0;
    case (i_rdata[15:8])
      8'h10, 8'h11, 8'h12,
      8'h20, 8'h21, 8'h22, 8'h23,
      8'h30, 8'h31, 8'h32,
      8'h40, 8'h41,
      8'h50, 8'h51, 8'h52, 8'h53,
      8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66,
      8'h70, 8'h80, 8'hF0: w_two = 1'b1;
      default:             w_two = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_cap1        = 1'b0;
    w_cap2        = 1'b0;
    o_re          = 1'b0;
    o_instr_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_run) w_state_nxt = S_FETCH1;
      end
      S_FETCH1: begin
        o_re        = 1'b1;
        w_cap1      = 1'b1;
        w_pc_nxt    = r_pc + 16'd1;
        w_state_nxt = w_two ? S_FETCH2 : S_HOLD;
      end
      S_FETCH2: begin
        o_re        = 1'b1;
        w_cap2      = 1'b1;
        w_pc_nxt    = r_pc + 16'd1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        o_instr_valid = 1'b1;
        if (i_instr_ready) w_state_nxt = i_run ? S_FETCH1 : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A redirect wins over the handshake; a concurrent accept still counts as consumed.
    if (i_redirect) begin
      w_pc_nxt    = i_redirect_pc;
      w_cap1      = 1'b0;
      w_cap2      = 1'b0;
      w_state_nxt = i_run ? S_FETCH1 : S_IDLE;
    end
  end

  always_ff @(posedge i_mclk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_word1 <= 16'h0000;
      r_word2 <= 16'h0000;
      r_ipc   <= 16'h0000;
      r_len2  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_cap1) begin
        r_word1 <= i_rdata;
        r_ipc   <= r_pc;
        r_word2 <= 16'h0000;
        r_len2  <= 1'b0;
      end
      if (w_cap2) begin
        r_word2 <= i_rdata;
        r_len2  <= 1'b1;
      end
    end
  end

  assign o_raddr       = r_pc;
  assign o_instr_word1 = r_word1;
  assign o_instr_word2 = r_word2;
  assign o_instr_len2  = r_len2;
  assign o_instr_pc    = r_ipc;

endmodule

// File: tb/tb_comet2_fetch_unit.sv
// Bench for comet2_fetch_unit: directed scenarios plus a randomized run against an instruction-stream model.
module tb_comet2_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run, rdy, redirect;
  logic [15:0] redirect_pc;
  logic        re, valid, len2;
  logic [15:0] raddr, rdata, w1, w2, ipc;
  logic        re_b, valid_b, len2_b;
  logic [15:0] raddr_b, rdata_b, w1_b, w2_b, ipc_b;
  logic [15:0] ram [256];

  int errors = 0;
  int checks = 0;

  assign rdata   = ram[raddr[7:0]];
  assign rdata_b = ram[raddr_b[7:0]];

  comet2_fetch_unit u_dut (
    .i_mclk(clk), .i_rst(rst), .i_run(run),
    .o_re(re), .o_raddr(raddr), .i_rdata(rdata),
    .o_instr_valid(valid), .i_instr_ready(rdy),
    .o_instr_word1(w1), .o_instr_word2(w2), .o_instr_len2(len2), .o_instr_pc(ipc),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc)
  );

  comet2_fetch_unit #(.RESET_PC(16'hFFFF)) u_dut_hi (
    .i_mclk(clk), .i_rst(rst), .i_run(run),
    .o_re(re_b), .o_raddr(raddr_b), .i_rdata(rdata_b),
    .o_instr_valid(valid_b), .i_instr_ready(rdy),
    .o_instr_word1(w1_b), .o_instr_word2(w2_b), .o_instr_len2(len2_b), .o_instr_pc(ipc_b),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc)
  );

  // Instruction-length rule from the opcode table.
  function automatic bit two_word(input logic [7:0] op);
    return op inside {[8'h10:8'h12], [8'h20:8'h23], [8'h30:8'h32], [8'h40:8'h41],
                      [8'h50:8'h53], [8'h61:8'h66], 8'h70, 8'h80, 8'hF0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; rdy = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_ram();
    do_reset();
    checks++; if (re !== 1'b0) begin errors++; $display("FAIL rst_re got=%0h exp=0", re); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", valid); end
    checks++; if (w1 !== 16'h0000) begin errors++; $display("FAIL rst_word1 got=%h exp=0000", w1); end
    checks++; if (w2 !== 16'h0000) begin errors++; $display("FAIL rst_word2 got=%h exp=0000", w2); end
    checks++; if (ipc !== 16'h0000) begin errors++; $display("FAIL rst_pc got=%h exp=0000", ipc); end
    checks++; if (len2 !== 1'b0) begin errors++; $display("FAIL rst_len2 got=%0h exp=0", len2); end
    checks++; if (raddr !== 16'h0000) begin errors++; $display("FAIL rst_raddr got=%h exp=0000", raddr); end
    checks++; if (raddr_b !== 16'hFFFF) begin errors++; $display("FAIL rst_raddr_hi got=%h exp=ffff", raddr_b); end
  endtask

  task automatic test_one_word_stream();
    logic [15:0] k;
    clear_ram();
    do_reset();
    run = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 4 && re !== 1'b1; i++) cyc();
    checks++; if (re !== 1'b1 || raddr !== 16'h0000) begin errors++; $display("FAIL ow_first got re=%0h raddr=%h exp re=1 raddr=0000", re, raddr); end
    for (int i = 0; i < 5; i++) begin
      k = 16'(i);
      cyc();
      checks++;
      if (valid !== 1'b1 || ipc !== k || len2 !== 1'b0 || re !== 1'b0)
        begin errors++; $display("FAIL ow_hold got v=%0h pc=%h l2=%0h re=%0h exp v=1 pc=%h l2=0 re=0", valid, ipc, len2, re, k); end
      cyc();
      checks++;
      if (re !== 1'b1 || raddr !== k + 16'd1 || valid !== 1'b0)
        begin errors++; $display("FAIL ow_fetch got re=%0h raddr=%h v=%0h exp re=1 raddr=%h v=0", re, raddr, valid, k + 16'd1); end
    end
  endtask

  task automatic test_two_word_and_backpressure();
    clear_ram();
    ram[0] = 16'h1010; ram[1] = 16'h0075; ram[2] = 16'h1412;
    do_reset();
    run = 1'b1; rdy = 1'b1;
    cyc();
    checks++; if (re !== 1'b1 || raddr !== 16'h0000 || valid !== 1'b0) begin errors++; $display("FAIL tw_f1 got re=%0h raddr=%h v=%0h exp 1/0000/0", re, raddr, valid); end
    cyc();
    checks++; if (re !== 1'b1 || raddr !== 16'h0001 || valid !== 1'b0) begin errors++; $display("FAIL tw_f2 got re=%0h raddr=%h v=%0h exp 1/0001/0", re, raddr, valid); end
    cyc();
    checks++;
    if (valid !== 1'b1 || w1 !== 16'h1010 || w2 !== 16'h0075 || len2 !== 1'b1 || ipc !== 16'h0000)
      begin errors++; $display("FAIL tw_instr got v=%0h w1=%h w2=%h l2=%0h pc=%h exp 1/1010/0075/1/0000", valid, w1, w2, len2, ipc); end
    cyc();
    checks++; if (re !== 1'b1 || raddr !== 16'h0002) begin errors++; $display("FAIL tw_next got re=%0h raddr=%h exp 1/0002", re, raddr); end
    cyc();
    checks++;
    if (valid !== 1'b1 || w1 !== 16'h1412 || w2 !== 16'h0000 || len2 !== 1'b0 || ipc !== 16'h0002)
      begin errors++; $display("FAIL ow_instr got v=%0h w1=%h w2=%h l2=%0h pc=%h exp 1/1412/0000/0/0002", valid, w1, w2, len2, ipc); end
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (valid !== 1'b1 || w1 !== 16'h1412 || ipc !== 16'h0002 || re !== 1'b0 || raddr !== 16'h0003)
        begin errors++; $display("FAIL bp_hold got v=%0h w1=%h pc=%h re=%0h raddr=%h exp 1/1412/0002/0/0003", valid, w1, ipc, re, raddr); end
    end
    rdy = 1'b1;
    cyc();
    checks++; if (re !== 1'b1 || raddr !== 16'h0003 || valid !== 1'b0) begin errors++; $display("FAIL bp_release got re=%0h raddr=%h v=%0h exp 1/0003/0", re, raddr, valid); end
  endtask

  // Continues from FETCH1 at address 0003 left by the previous scenario.
  task automatic test_redirect();
    ram[3] = 16'h2000; ram[4] = 16'h1234; ram[8'h60] = 16'h1400;
    cyc();
    checks++; if (re !== 1'b1 || raddr !== 16'h0004) begin errors++; $display("FAIL rd_f2 got re=%0h raddr=%h exp 1/0004", re, raddr); end
    redirect = 1'b1; redirect_pc = 16'h0060;
    cyc();
    redirect = 1'b0;
    checks++; if (valid !== 1'b0 || re !== 1'b1 || raddr !== 16'h0060) begin errors++; $display("FAIL rd_target got v=%0h re=%0h raddr=%h exp 0/1/0060", valid, re, raddr); end
    cyc();
    checks++;
    if (valid !== 1'b1 || ipc !== 16'h0060 || w1 !== 16'h1400 || len2 !== 1'b0)
      begin errors++; $display("FAIL rd_instr got v=%0h pc=%h w1=%h l2=%0h exp 1/0060/1400/0", valid, ipc, w1, len2); end
    redirect = 1'b1; redirect_pc = 16'h0080;
    cyc();
    redirect = 1'b0;
    checks++; if (valid !== 1'b0 || re !== 1'b1 || raddr !== 16'h0080) begin errors++; $display("FAIL rd_accept got v=%0h re=%0h raddr=%h exp 0/1/0080", valid, re, raddr); end
  endtask

  task automatic test_wrap();
    clear_ram();
    ram[8'hFF] = 16'h6400; ram[8'h00] = 16'h0010;
    do_reset();
    run = 1'b1; rdy = 1'b1;
    cyc();
    checks++; if (re_b !== 1'b1 || raddr_b !== 16'hFFFF) begin errors++; $display("FAIL wr_f1 got re=%0h raddr=%h exp 1/ffff", re_b, raddr_b); end
    cyc();
    checks++; if (re_b !== 1'b1 || raddr_b !== 16'h0000) begin errors++; $display("FAIL wr_f2 got re=%0h raddr=%h exp 1/0000", re_b, raddr_b); end
    cyc();
    checks++;
    if (valid_b !== 1'b1 || w1_b !== 16'h6400 || w2_b !== 16'h0010 || len2_b !== 1'b1 || ipc_b !== 16'hFFFF)
      begin errors++; $display("FAIL wr_instr got v=%0h w1=%h w2=%h l2=%0h pc=%h exp 1/6400/0010/1/ffff", valid_b, w1_b, w2_b, len2_b, ipc_b); end
    cyc();
    checks++; if (re_b !== 1'b1 || raddr_b !== 16'h0001) begin errors++; $display("FAIL wr_next got re=%0h raddr=%h exp 1/0001", re_b, raddr_b); end
  endtask

  task automatic test_run_stop_and_reset();
    clear_ram();
    ram[0] = 16'h0100; ram[1] = 16'h1000; ram[2] = 16'h5555;
    do_reset();
    run = 1'b1; rdy = 1'b0;
    cyc();
    cyc();
    checks++; if (valid !== 1'b1 || ipc !== 16'h0000) begin errors++; $display("FAIL rs_hold got v=%0h pc=%h exp 1/0000", valid, ipc); end
    run = 1'b0;
    cyc();
    rdy = 1'b1;
    cyc();
    rdy = 1'b0;
    checks++; if (re !== 1'b0 || valid !== 1'b0 || raddr !== 16'h0001) begin errors++; $display("FAIL rs_idle got re=%0h v=%0h raddr=%h exp 0/0/0001", re, valid, raddr); end
    cyc();
    checks++; if (re !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL rs_idle2 got re=%0h v=%0h exp 0/0", re, valid); end
    run = 1'b1;
    cyc();
    checks++; if (re !== 1'b1 || raddr !== 16'h0001) begin errors++; $display("FAIL rs_resume got re=%0h raddr=%h exp 1/0001", re, raddr); end
    run = 1'b0;
    cyc();
    checks++; if (re !== 1'b1 || raddr !== 16'h0002) begin errors++; $display("FAIL rs_f2_norun got re=%0h raddr=%h exp 1/0002", re, raddr); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (valid !== 1'b0 || re !== 1'b0 || raddr !== 16'h0000 || w1 !== 16'h0000 || ipc !== 16'h0000)
      begin errors++; $display("FAIL rs_midreset got v=%0h re=%0h raddr=%h w1=%h pc=%h exp 0/0/0000/0000/0000", valid, re, raddr, w1, ipc); end
  endtask

  // Model: the accepted instruction stream is a walk through RAM from the current pc,
  // stepping by the opcode's length and jumping on every redirect.
  task automatic test_random();
    logic [15:0] pc_m, ew1, ew2;
    logic        elen;
    int          accepts = 0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'($urandom);
      if ($urandom_range(0, 1) == 1) ram[i][15:8] = 8'h10 + 8'($urandom_range(0, 2));
    end
    do_reset();
    pc_m = 16'h0000;
    for (int c = 0; c < 600; c++) begin
      rdy         = ($urandom_range(0, 3) != 0);
      run         = ($urandom_range(0, 7) != 0);
      redirect    = ($urandom_range(0, 29) == 0);
      redirect_pc = 16'($urandom);
      if (re === 1'b1) begin
        checks++;
        if (raddr !== pc_m && raddr !== pc_m + 16'd1)
          begin errors++; $display("FAIL rnd_raddr got=%h exp=%h or %h", raddr, pc_m, pc_m + 16'd1); end
      end
      if (valid === 1'b1 && rdy) begin
        ew1  = ram[pc_m[7:0]];
        elen = two_word(ew1[15:8]);
        ew2  = elen ? ram[8'(pc_m[7:0] + 8'd1)] : 16'h0000;
        accepts++;
        checks++;
        if (w1 !== ew1 || w2 !== ew2 || len2 !== elen || ipc !== pc_m || re !== 1'b0)
          begin errors++; $display("FAIL rnd_instr got w1=%h w2=%h l2=%0h pc=%h re=%0h exp %h/%h/%0h/%h/0", w1, w2, len2, ipc, re, ew1, ew2, elen, pc_m); end
        pc_m = pc_m + (elen ? 16'd2 : 16'd1);
      end
      if (redirect) pc_m = redirect_pc;
      cyc();
    end
    redirect = 1'b0;
    checks++; if (accepts < 30) begin errors++; $display("FAIL rnd_progress got=%0d exp>=30", accepts); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_one_word_stream();
    test_two_word_and_backpressure();
    test_redirect();
    test_wrap();
    test_run_stop_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
